audio_sample_sequencer: RTL and testbench
=========================================

Name: audio_sample_sequencer

Overview:
- Sequences one mono sample at a time from the codec left ADC stream (Avalon-ST source) through the pitch-processing engine, then presents the result on both codec DAC sinks (left and right).
- Provides a bypass path for dry passthrough.
- Provides a watchdog that substitutes the dry sample if the engine stalls, so the DAC never starves.
- Sits between the audio codec core and the pitch engine in the audio top level.

Parameters:
DATA_W, 16, sample width in bits
TIMEOUT, 2048, maximum cycles spent waiting for proc_ack before dry fallback (must be >= 2)
CNT_W, 16, width of the timeout_count status counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
in_data  in  DATA_W  left ADC sample from codec source
in_valid  in  1  in_data valid
in_ready  out  1  sequencer can accept a sample
bypass  in  1  1 = route dry sample directly to outputs
proc_req  out  1  request to pitch engine; held until ack or timeout
proc_data  out  DATA_W  sample handed to engine; stable while proc_req=1
proc_ack  in  1  one-cycle pulse; proc_result valid in that cycle
proc_result  in  DATA_W  processed sample
left_out_data  out  DATA_W  to codec left sink
left_out_valid  out  1  left sample valid
left_out_ready  in  1  left sink ready
right_out_data  out  DATA_W  to codec right sink
right_out_valid  out  1  right sample valid
right_out_ready  in  1  right sink ready
busy  out  1  state != IDLE
timeout_count  out  CNT_W  number of engine timeouts, saturating

Behaviour:
- Avalon-ST handshakes use readyLatency 0: a transfer occurs in any cycle where valid=1 and ready=1.
- Reset (reset=0 at a clk edge):
  - state -> IDLE; all outputs 0, including in_ready, proc_req, both out valids/data, proc_data and timeout_count.
  - The wait counter clears.
  - Reset mid-operation discards the in-flight sample; no partial output is emitted after reset.
- in_ready = 1 exactly when reset=1 and state=IDLE, decoded from the state register only (no combinational path from any input).
- States:
  - IDLE:
    - On an in_valid&in_ready transfer: capture in_data into the dry register.
    - If bypass=1 in that cycle: load both out data regs with in_data, set both valids, go to OUT.
    - Else: proc_data <= in_data, proc_req <= 1, clear the wait counter, go to PROC.
  - PROC:
    - proc_req=1 and proc_data held constant.
    - wait counter increments each cycle.
    - If proc_ack=1: capture proc_result into both out data regs, set both valids, proc_req <= 0, go to OUT.
    - Else if wait counter = TIMEOUT-1: load the dry sample into both out data regs, set both valids, proc_req <= 0, timeout_count += 1 (holds at all-ones), go to OUT.
    - proc_ack and timeout in the same cycle: ack wins, and timeout_count is not incremented.
    - bypass changes during PROC are ignored.
  - OUT:
    - Each channel is independent: its valid clears in the cycle after its valid&ready handshake. Data is held until then.
    - When both channels have completed, go to IDLE.
    - If both handshakes occur in the same cycle, go to IDLE next cycle.
    - A channel whose ready never rises keeps the sequencer in OUT indefinitely. There is no output timeout.
- Latency:
  - Bypass: sample accepted at edge N; both valids high from edge N+1.
  - Processed: proc_req high from edge N+1; proc_ack seen at edge M; valids high from edge M+1.
  - Timeout: valids high exactly TIMEOUT cycles after proc_req rises.
  - in_ready is high again the cycle after the last channel handshake.
- proc_ack outside PROC is ignored, with no state change.
- busy is registered-state decoded: 1 in PROC and in OUT.
- Upstream backpressure: samples offered while busy see in_ready=0. The sequencer neither latches nor counts them.
- Width rule: all data paths are DATA_W wide, with no arithmetic on samples. The wait counter is clog2(TIMEOUT) bits wide.

Test Plan:
1. Reset low 3 cycles with in_valid=1, in_data=16'h1234 -> in_ready=0, all outputs 0. After release, in_ready=1 next cycle, busy=0.
2. bypass=1, push 16'hA5A5, both readies=1 -> left/right_out_data=16'hA5A5 with valids high 1 cycle after accept, then low; in_ready returns to 1; proc_req never asserted.
3. bypass=0, push 16'h0100; engine pulses proc_ack with proc_result=16'h0080 five cycles after proc_req -> proc_data=16'h0100 stable throughout; both outputs=16'h0080; timeout_count=0.
4. bypass=0, TIMEOUT=8, engine silent, push 16'h7FFF -> proc_req high for exactly 8 cycles; outputs=16'h7FFF; timeout_count=1. Variant with ack on the 8th cycle -> result used, count unchanged.
5. Skewed sinks: left_out_ready=1, right_out_ready held 0 for 10 cycles -> left valid drops after 1 cycle; right valid and data held 10 cycles; in_ready stays 0 until the right handshake completes.
6. Assert reset during PROC and during OUT -> proc_req and valids fall on the reset edge; a stray proc_ack after reset is ignored; the next sample sequences normally.

Source files
------------

// File: rtl/audio_sample_sequencer.sv
// ---------------------------------------------------------------------------
// audio_sample_sequencer: one-sample-at-a-time ADC -> pitch engine -> L/R DAC
// sequencer with dry bypass and an engine-stall watchdog.      Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_sample_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 2048,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bypass,
  output logic              proc_req,
  output logic [DATA_W-1:0] proc_data,
  input  logic              proc_ack,
  input  logic [DATA_W-1:0] proc_result,
  output logic [DATA_W-1:0] left_out_data,
  output logic              left_out_valid,
  input  logic              left_out_ready,
  output logic [DATA_W-1:0] right_out_data,
  output logic              right_out_valid,
  input  logic              right_out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  timeout_count
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic [DATA_W-1:0]  r_dry;
  logic [DATA_W-1:0]  r_proc_data;
  logic               r_proc_req;
  logic [WAIT_W-1:0]  r_wait;
  logic [DATA_W-1:0]  r_left_data;
  logic [DATA_W-1:0]  r_right_data;
  logic               r_left_valid;
  logic               r_right_valid;
  logic [CNT_W-1:0]   r_tcount;

  logic               w_accept;
  logic               w_start_proc;
  logic               w_load_out;
  logic               w_timeout;
  logic [DATA_W-1:0]  w_out_sample;
  logic               w_left_done;
  logic               w_right_done;

  // A channel counts as done once its valid is gone or it handshakes this cycle.
  assign w_left_done  = !r_left_valid  || left_out_ready;
  assign w_right_done = !r_right_valid || right_out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_start_proc = 1'b0;
    w_load_out   = 1'b0;
    w_timeout    = 1'b0;
    w_out_sample = r_dry;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept = 1'b1;
          if (bypass) begin
            w_load_out   = 1'b1;
            w_out_sample = in_data;
            w_state_nxt  = S_OUT;
          end else begin
            w_start_proc = 1'b1;
            w_state_nxt  = S_PROC;
          end
        end
      end
      S_PROC: begin
        // Ack has priority over a watchdog expiry in the same cycle.
        if (proc_ack) begin
          w_load_out   = 1'b1;
          w_out_sample = proc_result;
          w_state_nxt  = S_OUT;
        end else if (r_wait == c_wait_last) begin
          w_load_out   = 1'b1;
          w_timeout    = 1'b1;
          w_state_nxt  = S_OUT;
        end
      end
      S_OUT: begin
        if (w_left_done && w_right_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b0;
      r_dry         <= '0;
      r_proc_data   <= '0;
      r_proc_req    <= 1'b0;
      r_wait        <= '0;
      r_left_data   <= '0;
      r_right_data  <= '0;
      r_left_valid  <= 1'b0;
      r_right_valid <= 1'b0;
      r_tcount      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) r_dry <= in_data;
      if (r_state == S_PROC) r_wait <= r_wait + WAIT_W'(1);
      if (w_start_proc) begin
        r_proc_data <= in_data;
        r_proc_req  <= 1'b1;
        r_wait      <= '0;
      end
      if (w_load_out) begin
        r_left_data   <= w_out_sample;
        r_right_data  <= w_out_sample;
        r_left_valid  <= 1'b1;
        r_right_valid <= 1'b1;
        r_proc_req    <= 1'b0;
      end else begin
        if (r_left_valid && left_out_ready)   r_left_valid  <= 1'b0;
        if (r_right_valid && right_out_ready) r_right_valid <= 1'b0;
      end
      if (w_timeout && (r_tcount != {CNT_W{1'b1}})) r_tcount <= r_tcount + CNT_W'(1);
    end
  end

  assign in_ready        = r_in_ready;
  assign busy            = (r_state != S_IDLE);
  assign proc_req        = r_proc_req;
  assign proc_data       = r_proc_data;
  assign left_out_data   = r_left_data;
  assign left_out_valid  = r_left_valid;
  assign right_out_data  = r_right_data;
  assign right_out_valid = r_right_valid;
  assign timeout_count   = r_tcount;

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_sequencer: randomized transaction bench with timing model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_audio_sample_sequencer;

  localparam int DW = 16;
  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          bypass = 1'b0;
  logic          proc_req;
  logic [DW-1:0] proc_data;
  logic          proc_ack = 1'b0;
  logic [DW-1:0] proc_result = '0;
  logic [DW-1:0] left_out_data;
  logic          left_out_valid;
  logic          left_out_ready = 1'b0;
  logic [DW-1:0] right_out_data;
  logic          right_out_valid;
  logic          right_out_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] timeout_count;

  int n_total = 0;
  int n_bad   = 0;
  int exp_tc  = 0;

  always #5 clk = ~clk;

  audio_sample_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .bypass          (bypass),
    .proc_req        (proc_req),
    .proc_data       (proc_data),
    .proc_ack        (proc_ack),
    .proc_result     (proc_result),
    .left_out_data   (left_out_data),
    .left_out_valid  (left_out_valid),
    .left_out_ready  (left_out_ready),
    .right_out_data  (right_out_data),
    .right_out_valid (right_out_valid),
    .right_out_ready (right_out_ready),
    .busy            (busy),
    .timeout_count   (timeout_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_proc_req"}, 32'(proc_req), 0);
    chk({tag, "_lvalid"},   32'(left_out_valid), 0);
    chk({tag, "_rvalid"},   32'(right_out_valid), 0);
    chk({tag, "_busy"},     32'(busy), 0);
  endtask

  // Hold reset low for n cycles while a sample is being offered.
  task automatic do_reset(input int n);
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    repeat (n) begin
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_ldata", 32'(left_out_data), 0);
      chk("rst_rdata", 32'(right_out_data), 0);
      chk("rst_proc_data", 32'(proc_data), 0);
      chk("rst_tcount", 32'(timeout_count), 0);
    end
    exp_tc = 0;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 1);
    chk_quiet("rel");
  endtask

  // One full sample: ad = PROC cycle index of the ack (>= TO means silent engine),
  // ld/rd = OUT cycle index in which each sink first raises ready.
  task automatic run_sample(input logic [DW-1:0] d, input logic byp, input int ad,
                            input logic [DW-1:0] res, input int ld, input int rd);
    logic [DW-1:0] exp_out;
    int n_req;
    int cmax;
    chk("idle_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = d; bypass = byp;
    @(negedge clk);
    in_valid = 1'($urandom); in_data = DW'($urandom);
    if (byp) begin
      exp_out = d;
    end else begin
      n_req   = (ad < TO) ? ad + 1 : TO;
      exp_out = (ad < TO) ? res : d;
      if (ad >= TO && exp_tc < (1 << CW) - 1) exp_tc++;
      for (int k = 0; k < n_req; k++) begin
        chk("proc_req", 32'(proc_req), 1);
        chk("proc_data", 32'(proc_data), 32'(d));
        chk("proc_busy", 32'(busy), 1);
        chk("proc_in_ready", 32'(in_ready), 0);
        chk("proc_lvalid", 32'(left_out_valid), 0);
        proc_ack    = (k == ad);
        proc_result = (k == ad) ? res : DW'($urandom);
        bypass      = 1'($urandom);
        in_valid    = 1'($urandom);
        in_data     = DW'($urandom);
        @(negedge clk);
      end
      proc_ack = 1'b0;
    end
    cmax = (ld > rd) ? ld : rd;
    for (int c = 0; c <= cmax; c++) begin
      chk("out_proc_req", 32'(proc_req), 0);
      chk("out_in_ready", 32'(in_ready), 0);
      chk("out_busy", 32'(busy), 1);
      chk("out_lvalid", 32'(left_out_valid), 32'(c <= ld));
      chk("out_rvalid", 32'(right_out_valid), 32'(c <= rd));
      if (c <= ld) chk("out_ldata", 32'(left_out_data), 32'(exp_out));
      if (c <= rd) chk("out_rdata", 32'(right_out_data), 32'(exp_out));
      left_out_ready  = (c >= ld) && ((c == ld) || 1'($urandom));
      right_out_ready = (c >= rd) && ((c == rd) || 1'($urandom));
      proc_ack        = (c == 0) && !byp && (ad == TO);
      proc_result     = DW'($urandom);
      in_valid        = 1'($urandom);
      in_data         = DW'($urandom);
      bypass          = 1'($urandom);
      @(negedge clk);
    end
    proc_ack = 1'b0; in_valid = 1'b0;
    left_out_ready = 1'($urandom); right_out_ready = 1'($urandom);
    chk("end_in_ready", 32'(in_ready), 1);
    chk_quiet("end");
    chk("end_tcount", 32'(timeout_count), 32'(exp_tc));
  endtask

  // Start a sample, let it sit in PROC or OUT for cyc cycles, then reset it away.
  task automatic abort_sample(input logic byp, input int cyc);
    left_out_ready = 1'b0; right_out_ready = 1'b0;
    in_valid = 1'b1; in_data = DW'($urandom); bypass = byp;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_state", byp ? 32'(left_out_valid) : 32'(proc_req), 1);
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("abort");
    chk("abort_in_ready", 32'(in_ready), 0);
    exp_tc = 0;
    reset = 1'b1; proc_ack = 1'b1; proc_result = DW'($urandom);
    @(negedge clk);
    proc_ack = 1'b0;
    chk("stray_in_ready", 32'(in_ready), 1);
    chk_quiet("stray");
    @(negedge clk);
    chk_quiet("stray2");
    chk("stray_tcount", 32'(timeout_count), 0);
  endtask

  initial begin
    do_reset(3);
    run_sample(16'hA5A5, 1'b1, 0, 16'h0000, 0, 0);
    run_sample(16'h0100, 1'b0, 5, 16'h0080, 0, 0);
    run_sample(16'h7FFF, 1'b0, TO + 1, 16'h0000, 0, 0);
    run_sample(16'h7FFF, 1'b0, TO - 1, 16'h1357, 0, 0);
    run_sample(16'h2222, 1'b0, 0, 16'h3333, 0, 10);
    run_sample(16'h6666, 1'b1, 0, 16'h0000, 10, 0);
    abort_sample(1'b0, 2);
    abort_sample(1'b1, 3);
    run_sample(16'h4444, 1'b0, 3, 16'h5555, 1, 1);
    for (int i = 0; i < 60; i++) begin
      run_sample(DW'($urandom), 1'($urandom), int'($urandom_range(0, TO + 1)),
                 DW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
